tlp_tx_sched: RTL and testbench
===============================

// Module: tlp_tx_sched
// PURPOSE
//  Downstream stage of the Ethernet TLP decapsulator, in the PCIe user-clock domain.
//  - Drains the dual-clock TLP FIFO (PCIE_FIFO64_TX words, first-word-fall-through).
//  - Starts an injected packet only when the whole packet is already in the FIFO.
//  - Merges injected packets with a local TLP source at packet boundaries.
//  - Drives the PCIe core s_axis_tx interface.
//  - Converts the writer's forced-tlast error marker into a PCIe source-discontinue.
// PARAMETERS
//  PKT_CNT_W     8  width of the complete-packet counter (FIFO depth in packets must be < 2**PKT_CNT_W)
//  LOC_PRIORITY  0  0 = round-robin between injected and local; 1 = local strict priority
//  TUSER_DSC_BIT 3  index of src_dsc within tuser
// PORTS
//  pcie_clk          in   1   PCIe user clock
//  pcie_rst_n        in   1   reset, asynchronous, active-low
//  pkt_done_tgl      in   1   eth_clk-domain toggle; flips once per writer fifo_read_req pulse
//  fifo_rd_en        out  1   FWFT pop
//  fifo_dout         in   PCIE_FIFO64_TX  head word {tvalid,tlast,tkeep,tdata,tuser}
//  fifo_empty        in   1   FIFO empty
//  loc_tvalid/tready in/out 1 local TLP source handshake
//  loc_tdata/tkeep   in   64/8  local data / byte enables
//  loc_tlast         in   1   local last beat
//  loc_tuser         in   4   local tuser
//  s_axis_tx_tvalid  out  1   to PCIe core
//  s_axis_tx_tready  in   1   from PCIe core
//  s_axis_tx_tdata   out  64  data
//  s_axis_tx_tkeep   out  8   byte enables
//  s_axis_tx_tlast   out  1   last beat
//  s_axis_tx_tuser   out  4   tuser; bit TUSER_DSC_BIT = discontinue
//  pkt_pending       out  PKT_CNT_W  complete packets waiting in FIFO
// BEHAVIOUR
//  - Reset: all outputs 0; pkt_cnt, sync flops, rr pointer 0; state IDLE.
//    Reset mid-packet truncates the packet silently. The FIFO is reset together with this block.
//  - Sync: pkt_done_tgl passes a 2-FF synchronizer, then an XOR edge detect, giving a 1-cycle inc pulse.
//    Latency: 3 pcie_clk cycles from toggle to pkt_pending update.
//  - pkt_cnt update per cycle:
//    - +1 on inc; -1 on grant to INJ; inc and grant together leave it unchanged.
//    - Saturates at all-ones; an inc there is lost, so the depth limit is mandatory.
//  - FSM, grant decided in IDLE, one cycle idle between packets:
//    - IDLE -> INJ when pkt_cnt != 0 and (loc_tvalid == 0, or rr favours INJ, or LOC_PRIORITY == 0 and the last grant was LOC).
//    - IDLE -> LOC when loc_tvalid and not going to INJ. Record the last grant.
//    - INJ: data path is combinational from FWFT head to s_axis_tx. Track beat_sent (≥1 beat of this packet accepted).
//      - Head tvalid=1: drive s_axis_tx_tvalid = !fifo_empty, data, tkeep and tlast from the head, tuser = 0.
//        fifo_rd_en = tvalid & tready. A tlast beat accepted -> IDLE.
//      - Head tvalid=0, tlast=1 (error marker), beat_sent=0: pop without output, dsc-drop -> IDLE.
//      - Head tvalid=0, tlast=1 (error marker), beat_sent=1: drive one beat, tdata=0, tkeep=8'hFF, tlast=1, tuser[TUSER_DSC_BIT]=1.
//        Pop on tready -> IDLE.
//      - Head tvalid=0, tlast=0: pop, discard, stay.
//      - fifo_empty mid-packet: tvalid=0, wait. This is legal because the packet is known complete.
//    - LOC: s_axis_tx_* = loc_*; loc_tready = s_axis_tx_tready. Accepted loc_tlast -> IDLE.
//      loc_tready = 0 in every other state.
//  - AXIS rules: once tvalid is asserted, data holds until tready, guaranteed by FWFT head stability. No beats from the two sources interleave.
//  - pkt_pending = pkt_cnt, registered.
// CONFIGURATION
//  TLP_TX_SCHED_STATS_EN
//   - Defined: adds three 32-bit wrapping output counters, each +1 per event, reset 0:
//     - stat_inj_pkts: injected packets completed normally.
//     - stat_loc_pkts: local packets completed.
//     - stat_dsc_pkts: discontinued plus silently dropped packets.
//   - Undefined: ports and logic absent; no other behaviour change.
// STRUCTURE
//  - pcie_tlp_pkg: PCIE_FIFO64_TX (existing); new TLP_TUSER_DSC_BIT constant; AXIS_TX64_T struct for the s_axis_tx bundle.
//  - Sub-module toggle_sync: 2-FF synchronizer plus edge pulse, async active-low reset. Reusable for the cmd/pciecfg paths.
// TESTING
//  - Partial FIFO fill of 3 words with no toggle -> no s_axis_tx_tvalid. Toggle -> packet of 3 beats out, tlast on beat 3, pkt_pending 1->0.
//  - 2 complete packets queued, s_axis_tx_tready toggling 1/0 -> all 6 beats exact and in order, no dropped or duplicated beat.
//  - Error marker after 2 good beats -> 3rd beat has tlast=1, tuser[3]=1, tdata=0. Marker-only packet -> no output, stat_dsc_pkts=1.
//  - loc_tvalid held high, 2 injected packets pending, LOC_PRIORITY=0 -> order INJ, LOC, INJ, LOC. With LOC_PRIORITY=1 -> local first.
//  - inc pulse in the same cycle as a grant with pkt_cnt=1 -> pkt_cnt stays 1. 255 pending plus one more toggle -> stays 255.
//  - pcie_rst_n low mid-INJ -> s_axis_tx_tvalid 0 immediately. After release: IDLE, pkt_pending 0.

Source files
------------

// File: rtl/pcie_tlp_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Package : pcie_tlp_pkg                                                   |
// | Shared widths, field layout of the TX FIFO word, s_axis_tx bundle and    |
// | the TX scheduler state encoding.                                         |
// | Rev 1.0 : initial release                                                |
// +--------------------------------------------------------------------------+
package pcie_tlp_pkg;

   // Width of one TX FIFO word: {tvalid, tlast, tkeep[7:0], tdata[63:0], tuser[3:0]}
   localparam int PCIE_FIFO64_TX    = 78;
   // tuser bit the PCIe core interprets as source-discontinue
   localparam int TLP_TUSER_DSC_BIT = 3;

   // Field view of a TX FIFO word; tvalid=0 words are writer sideband markers
   typedef struct packed {
      logic        tvalid;
      logic        tlast;
      logic [7:0]  tkeep;
      logic [63:0] tdata;
      logic [3:0]  tuser;
   } FIFO64_WORD_T;

   // s_axis_tx bundle toward the PCIe core
   typedef struct packed {
      logic        tvalid;
      logic [63:0] tdata;
      logic [7:0]  tkeep;
      logic        tlast;
      logic [3:0]  tuser;
   } AXIS_TX64_T;

   // Scheduler state: grant decided in TX_IDLE, one packet per INJ/LOC visit
   typedef enum logic [1:0] {
      TX_IDLE = 2'd0,
      TX_INJ  = 2'd1,
      TX_LOC  = 2'd2
   } tx_state_t;

endpackage
`default_nettype wire

// File: rtl/toggle_sync.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module : toggle_sync                                                     |
// | Brings a foreign-domain toggle in through two flops and turns each       |
// | level change into a single-cycle pulse.                                  |
// | Rev 1.0 : initial release                                                |
// +--------------------------------------------------------------------------+
module toggle_sync (
   input  logic clk,
   input  logic rst_n,
   input  logic tgl_async,
   output logic pulse
);

   // [0],[1] are the synchronizer, [2] holds the previous synchronized level
   logic [2:0] sync_q;
   logic [2:0] sync_d;

   // Shift the toggle through the synchronizer and the edge-detect history
   always_comb begin
      sync_d = {sync_q[1:0], tgl_async};
   end

   // Synchronizer and history flops
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= 3'b000;
      end else begin
         sync_q <= sync_d;
      end
   end

   assign pulse = sync_q[1] ^ sync_q[2];

endmodule
`default_nettype wire

// File: rtl/tlp_tx_sched.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module : tlp_tx_sched                                                    |
// | Drains the FWFT TLP FIFO one complete packet at a time, merges it with a |
// | local TLP source at packet boundaries and drives s_axis_tx. Writer error |
// | markers become a source-discontinue beat or a silent drop.               |
// | Optional: TLP_TX_SCHED_STATS_EN adds packet statistic counters.          |
// | Rev 1.0 : initial release                                                |
// +--------------------------------------------------------------------------+
module tlp_tx_sched
   import pcie_tlp_pkg::*;
#(
   parameter int PKT_CNT_W     = 8,
   parameter int LOC_PRIORITY  = 0,
   parameter int TUSER_DSC_BIT = TLP_TUSER_DSC_BIT
) (
   input  logic                      pcie_clk,
   input  logic                      pcie_rst_n,
   input  logic                      pkt_done_tgl,
   output logic                      fifo_rd_en,
   input  logic [PCIE_FIFO64_TX-1:0] fifo_dout,
   input  logic                      fifo_empty,
   input  logic                      loc_tvalid,
   output logic                      loc_tready,
   input  logic [63:0]               loc_tdata,
   input  logic [7:0]                loc_tkeep,
   input  logic                      loc_tlast,
   input  logic [3:0]                loc_tuser,
   output logic                      s_axis_tx_tvalid,
   input  logic                      s_axis_tx_tready,
   output logic [63:0]               s_axis_tx_tdata,
   output logic [7:0]                s_axis_tx_tkeep,
   output logic                      s_axis_tx_tlast,
   output logic [3:0]                s_axis_tx_tuser,
   output logic [PKT_CNT_W-1:0]      pkt_pending
`ifdef TLP_TX_SCHED_STATS_EN
   ,
   output logic [31:0]               stat_inj_pkts,
   output logic [31:0]               stat_loc_pkts,
   output logic [31:0]               stat_dsc_pkts
`endif
);

   localparam logic [3:0] DSC_TUSER = 4'b0001 << TUSER_DSC_BIT;

   FIFO64_WORD_T         head;
   AXIS_TX64_T           tx;
   tx_state_t            state_q, state_d;
   logic [PKT_CNT_W-1:0] pkt_cnt_q, pkt_cnt_d;
   logic                 rr_q, rr_d;            // 0: injected source's turn, 1: local's turn
   logic                 beat_sent_q, beat_sent_d;
   logic                 inc, go_inj, grant_inj;
   logic                 ev_inj, ev_loc, ev_dsc;
   logic                 unused_head_tuser;

   assign head = fifo_dout;
   assign unused_head_tuser = ^head.tuser;

   toggle_sync u_done_sync (
      .clk       (pcie_clk),
      .rst_n     (pcie_rst_n),
      .tgl_async (pkt_done_tgl),
      .pulse     (inc)
   );

   // An injected packet may start only once it is known to be complete in the FIFO
   assign go_inj = (pkt_cnt_q != '0) &&
                   (!loc_tvalid || ((LOC_PRIORITY == 0) && !rr_q));

   // Next state, grant bookkeeping and the combinational s_axis_tx / pop datapath
   always_comb begin
      state_d     = state_q;
      rr_d        = rr_q;
      beat_sent_d = beat_sent_q;
      tx          = '0;
      fifo_rd_en  = 1'b0;
      loc_tready  = 1'b0;
      grant_inj   = 1'b0;
      ev_inj      = 1'b0;
      ev_loc      = 1'b0;
      ev_dsc      = 1'b0;
      case (state_q)
         TX_IDLE: begin
            beat_sent_d = 1'b0;
            if (go_inj) begin
               state_d   = TX_INJ;
               grant_inj = 1'b1;
               rr_d      = 1'b1;
            end else if (loc_tvalid) begin
               state_d = TX_LOC;
               rr_d    = 1'b0;
            end
         end
         TX_INJ: begin
            if (!fifo_empty) begin
               if (head.tvalid) begin
                  tx.tvalid  = 1'b1;
                  tx.tdata   = head.tdata;
                  tx.tkeep   = head.tkeep;
                  tx.tlast   = head.tlast;
                  fifo_rd_en = s_axis_tx_tready;
                  if (s_axis_tx_tready) begin
                     beat_sent_d = 1'b1;
                     if (head.tlast) begin
                        state_d = TX_IDLE;
                        ev_inj  = 1'b1;
                     end
                  end
               end else if (head.tlast) begin
                  // Writer error marker: nothing sent yet -> drop, else discontinue
                  if (!beat_sent_q) begin
                     fifo_rd_en = 1'b1;
                     state_d    = TX_IDLE;
                     ev_dsc     = 1'b1;
                  end else begin
                     tx.tvalid  = 1'b1;
                     tx.tkeep   = 8'hFF;
                     tx.tlast   = 1'b1;
                     tx.tuser   = DSC_TUSER;
                     fifo_rd_en = s_axis_tx_tready;
                     if (s_axis_tx_tready) begin
                        state_d = TX_IDLE;
                        ev_dsc  = 1'b1;
                     end
                  end
               end else begin
                  fifo_rd_en = 1'b1;
               end
            end
         end
         TX_LOC: begin
            tx.tvalid  = loc_tvalid;
            tx.tdata   = loc_tdata;
            tx.tkeep   = loc_tkeep;
            tx.tlast   = loc_tlast;
            tx.tuser   = loc_tuser;
            loc_tready = s_axis_tx_tready;
            if (loc_tvalid && s_axis_tx_tready && loc_tlast) begin
               state_d = TX_IDLE;
               ev_loc  = 1'b1;
            end
         end
         default: state_d = TX_IDLE;
      endcase
   end

   // Complete-packet count: arrivals minus injected grants, saturating at all-ones
   always_comb begin
      pkt_cnt_d = pkt_cnt_q;
      if (inc && !grant_inj) begin
         if (pkt_cnt_q != '1) begin
            pkt_cnt_d = pkt_cnt_q + PKT_CNT_W'(1);
         end
      end else if (!inc && grant_inj) begin
         pkt_cnt_d = pkt_cnt_q - PKT_CNT_W'(1);
      end
   end

   // Scheduler state, round-robin pointer, beat tracking and packet count
   always_ff @(posedge pcie_clk or negedge pcie_rst_n) begin
      if (!pcie_rst_n) begin
         state_q     <= TX_IDLE;
         pkt_cnt_q   <= '0;
         rr_q        <= 1'b0;
         beat_sent_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         pkt_cnt_q   <= pkt_cnt_d;
         rr_q        <= rr_d;
         beat_sent_q <= beat_sent_d;
      end
   end

   assign s_axis_tx_tvalid = tx.tvalid;
   assign s_axis_tx_tdata  = tx.tdata;
   assign s_axis_tx_tkeep  = tx.tkeep;
   assign s_axis_tx_tlast  = tx.tlast;
   assign s_axis_tx_tuser  = tx.tuser;
   assign pkt_pending      = pkt_cnt_q;

`ifdef TLP_TX_SCHED_STATS_EN
   logic [31:0] stat_inj_q, stat_inj_d;
   logic [31:0] stat_loc_q, stat_loc_d;
   logic [31:0] stat_dsc_q, stat_dsc_d;

   // Wrapping per-event packet counters
   always_comb begin
      stat_inj_d = stat_inj_q + {31'd0, ev_inj};
      stat_loc_d = stat_loc_q + {31'd0, ev_loc};
      stat_dsc_d = stat_dsc_q + {31'd0, ev_dsc};
   end

   // Statistic counter flops
   always_ff @(posedge pcie_clk or negedge pcie_rst_n) begin
      if (!pcie_rst_n) begin
         stat_inj_q <= 32'd0;
         stat_loc_q <= 32'd0;
         stat_dsc_q <= 32'd0;
      end else begin
         stat_inj_q <= stat_inj_d;
         stat_loc_q <= stat_loc_d;
         stat_dsc_q <= stat_dsc_d;
      end
   end

   assign stat_inj_pkts = stat_inj_q;
   assign stat_loc_pkts = stat_loc_q;
   assign stat_dsc_pkts = stat_dsc_q;
`else
   logic unused_events;
   assign unused_events = ev_inj ^ ev_loc ^ ev_dsc;
`endif

endmodule
`default_nettype wire

// File: tb/tb_tlp_tx_sched.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module : tb_tlp_tx_sched                                                 |
// | Directed bench for tlp_tx_sched with a queue-based FWFT FIFO and local   |
// | source model; a second instance covers local strict priority.            |
// | Rev 1.0 : initial release                                                |
// +--------------------------------------------------------------------------+
module tb_tlp_tx_sched;
   import pcie_tlp_pkg::*;

   typedef logic [76:0] beat_t;   // {tlast, tkeep, tdata, tuser}

   logic        pcie_clk = 1'b0;
   logic        pcie_rst_n;
   logic        pkt_done_tgl;
   logic        fifo_rd_en;
   logic [77:0] fifo_dout;
   logic        fifo_empty;
   logic        loc_tvalid, loc_tready, loc_tlast;
   logic [63:0] loc_tdata;
   logic [7:0]  loc_tkeep;
   logic [3:0]  loc_tuser;
   logic        s_axis_tx_tvalid, s_axis_tx_tready, s_axis_tx_tlast;
   logic [63:0] s_axis_tx_tdata;
   logic [7:0]  s_axis_tx_tkeep;
   logic [3:0]  s_axis_tx_tuser;
   logic [7:0]  pkt_pending;

   logic        tgl2, loc_tvalid2, loc_tready2, loc_tlast2, tx_tready2;
   logic [63:0] loc_tdata2, tx_tdata2;
   logic [7:0]  pkt_pending2;
   logic        unused_rd2, unused_tvalid2, unused_tlast2;
   logic [7:0]  unused_tkeep2;
   logic [3:0]  unused_tuser2;

`ifdef TLP_TX_SCHED_STATS_EN
   logic [31:0] stat_inj_pkts, stat_loc_pkts, stat_dsc_pkts;
   logic [31:0] unused_s2a, unused_s2b, unused_s2c;
   logic [31:0] dsc0;
`endif

   logic [77:0] fifo_q[$];
   beat_t       loc_q[$];
   beat_t       cap[$];
   beat_t       exp_q[$];
   int          n_chk  = 0;
   int          n_pass = 0;
   int          n_fail = 0;
   bit          tr_toggle = 1'b0;

   always #5 pcie_clk = ~pcie_clk;

   tlp_tx_sched #(.PKT_CNT_W(8), .LOC_PRIORITY(0), .TUSER_DSC_BIT(3)) dut (
      .pcie_clk(pcie_clk), .pcie_rst_n(pcie_rst_n), .pkt_done_tgl(pkt_done_tgl),
      .fifo_rd_en(fifo_rd_en), .fifo_dout(fifo_dout), .fifo_empty(fifo_empty),
      .loc_tvalid(loc_tvalid), .loc_tready(loc_tready), .loc_tdata(loc_tdata),
      .loc_tkeep(loc_tkeep), .loc_tlast(loc_tlast), .loc_tuser(loc_tuser),
      .s_axis_tx_tvalid(s_axis_tx_tvalid), .s_axis_tx_tready(s_axis_tx_tready),
      .s_axis_tx_tdata(s_axis_tx_tdata), .s_axis_tx_tkeep(s_axis_tx_tkeep),
      .s_axis_tx_tlast(s_axis_tx_tlast), .s_axis_tx_tuser(s_axis_tx_tuser),
      .pkt_pending(pkt_pending)
`ifdef TLP_TX_SCHED_STATS_EN
      , .stat_inj_pkts(stat_inj_pkts), .stat_loc_pkts(stat_loc_pkts),
      .stat_dsc_pkts(stat_dsc_pkts)
`endif
   );

   tlp_tx_sched #(.PKT_CNT_W(8), .LOC_PRIORITY(1), .TUSER_DSC_BIT(3)) dut_pri (
      .pcie_clk(pcie_clk), .pcie_rst_n(pcie_rst_n), .pkt_done_tgl(tgl2),
      .fifo_rd_en(unused_rd2), .fifo_dout(78'd0), .fifo_empty(1'b1),
      .loc_tvalid(loc_tvalid2), .loc_tready(loc_tready2), .loc_tdata(loc_tdata2),
      .loc_tkeep(8'hFF), .loc_tlast(loc_tlast2), .loc_tuser(4'h0),
      .s_axis_tx_tvalid(unused_tvalid2), .s_axis_tx_tready(tx_tready2),
      .s_axis_tx_tdata(tx_tdata2), .s_axis_tx_tkeep(unused_tkeep2),
      .s_axis_tx_tlast(unused_tlast2), .s_axis_tx_tuser(unused_tuser2),
      .pkt_pending(pkt_pending2)
`ifdef TLP_TX_SCHED_STATS_EN
      , .stat_inj_pkts(unused_s2a), .stat_loc_pkts(unused_s2b),
      .stat_dsc_pkts(unused_s2c)
`endif
   );

   function automatic logic [77:0] mkw(input logic v, input logic l,
                                       input logic [7:0] k, input logic [63:0] d);
      return {v, l, k, d, 4'h0};
   endfunction

   function automatic beat_t bt(input logic l, input logic [7:0] k,
                                input logic [63:0] d, input logic [3:0] u);
      return {l, k, d, u};
   endfunction

   task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Present FIFO head and local head to the DUT
   task automatic drive();
      fifo_empty = (fifo_q.size() == 0);
      fifo_dout  = fifo_empty ? 78'd0 : fifo_q[0];
      if (loc_q.size() != 0) begin
         loc_tvalid = 1'b1;
         {loc_tlast, loc_tkeep, loc_tdata, loc_tuser} = loc_q[0];
      end else begin
         loc_tvalid = 1'b0;
         {loc_tlast, loc_tkeep, loc_tdata, loc_tuser} = '0;
      end
   endtask

   // One clock: sample at negedge, apply pops just after posedge
   task automatic step();
      logic rd, la;
      @(negedge pcie_clk);
      if (s_axis_tx_tvalid && s_axis_tx_tready)
         cap.push_back({s_axis_tx_tlast, s_axis_tx_tkeep, s_axis_tx_tdata, s_axis_tx_tuser});
      rd = fifo_rd_en;
      la = loc_tvalid && loc_tready;
      @(posedge pcie_clk);
      #1;
      if (rd && fifo_q.size() != 0) void'(fifo_q.pop_front());
      if (la && loc_q.size() != 0) void'(loc_q.pop_front());
      if (tr_toggle) s_axis_tx_tready = ~s_axis_tx_tready;
      drive();
   endtask

   task automatic step_n(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic wait_beats(input int n, input int budget, input string tag);
      for (int i = 0; i < budget && cap.size() < n; i++) step();
      chk(tag, cap.size(), n);
   endtask

   task automatic check_cap(input string tag);
      beat_t got;
      for (int i = 0; i < exp_q.size(); i++) begin
         got = '1;
         if (i < cap.size()) got = cap[i];
         chk($sformatf("%s_beat%0d", tag, i), got, exp_q[i]);
      end
      exp_q.delete();
      cap.delete();
   endtask

   initial begin
      pcie_rst_n = 1'b0; pkt_done_tgl = 1'b0; s_axis_tx_tready = 1'b0;
      tgl2 = 1'b0; loc_tvalid2 = 1'b0; loc_tlast2 = 1'b0; loc_tdata2 = 64'h55; tx_tready2 = 1'b0;
      drive();
      step_n(3);
      chk("rst_tvalid", s_axis_tx_tvalid, 0);
      chk("rst_pending", pkt_pending, 0);
      chk("rst_rd_en", fifo_rd_en, 0);
      chk("rst_loc_tready", loc_tready, 0);
      pcie_rst_n = 1'b1;
      loc_tvalid2 = 1'b1;
      step_n(2);

      // Local strict priority instance: local wins with an injected packet pending
      tgl2 = ~tgl2;
      step_n(4);
      chk("pri_pending", pkt_pending2, 1);
      tx_tready2 = 1'b1; loc_tlast2 = 1'b1;
      step_n(2);
      chk("pri_loc_first", loc_tready2, 1);
      chk("pri_pending_kept", pkt_pending2, 1);
      chk("pri_loc_data", tx_tdata2, 64'h55);
      loc_tvalid2 = 1'b0; tx_tready2 = 1'b0;

      // Partial packet in FIFO is held back until its toggle arrives
      s_axis_tx_tready = 1'b1;
      fifo_q.push_back(mkw(1, 0, 8'hFF, 64'hA1));
      fifo_q.push_back(mkw(1, 0, 8'hFF, 64'hA2));
      fifo_q.push_back(mkw(1, 1, 8'h0F, 64'hA3));
      drive();
      step_n(6);
      chk("t1_no_out", cap.size(), 0);
      chk("t1_tvalid_idle", s_axis_tx_tvalid, 0);
      pkt_done_tgl = ~pkt_done_tgl;
      step_n(3);
      chk("t1_pending_1", pkt_pending, 1);
      step();
      chk("t1_pending_0", pkt_pending, 0);
      wait_beats(3, 20, "t1_nbeats");
      chk("t1_idle_after", s_axis_tx_tvalid, 0);
      exp_q.push_back(bt(0, 8'hFF, 64'hA1, 0));
      exp_q.push_back(bt(0, 8'hFF, 64'hA2, 0));
      exp_q.push_back(bt(1, 8'h0F, 64'hA3, 0));
      check_cap("t1");

      // Two packets with tready toggling every cycle
      tr_toggle = 1'b1;
      fifo_q.push_back(mkw(1, 0, 8'hFF, 64'hB1));
      fifo_q.push_back(mkw(1, 0, 8'hFF, 64'hB2));
      fifo_q.push_back(mkw(1, 1, 8'h01, 64'hB3));
      fifo_q.push_back(mkw(1, 0, 8'hFF, 64'hC1));
      fifo_q.push_back(mkw(1, 0, 8'hFF, 64'hC2));
      fifo_q.push_back(mkw(1, 1, 8'hFF, 64'hC3));
      drive();
      pkt_done_tgl = ~pkt_done_tgl;
      step_n(2);
      pkt_done_tgl = ~pkt_done_tgl;
      wait_beats(6, 80, "t2_nbeats");
      tr_toggle = 1'b0; s_axis_tx_tready = 1'b1;
      exp_q.push_back(bt(0, 8'hFF, 64'hB1, 0));
      exp_q.push_back(bt(0, 8'hFF, 64'hB2, 0));
      exp_q.push_back(bt(1, 8'h01, 64'hB3, 0));
      exp_q.push_back(bt(0, 8'hFF, 64'hC1, 0));
      exp_q.push_back(bt(0, 8'hFF, 64'hC2, 0));
      exp_q.push_back(bt(1, 8'hFF, 64'hC3, 0));
      check_cap("t2");
      step_n(2);
      chk("t2_fifo_drained", fifo_q.size(), 0);
      chk("t2_pending_0", pkt_pending, 0);
`ifdef TLP_TX_SCHED_STATS_EN
      chk("t2_stat_inj", stat_inj_pkts, 3);
      dsc0 = stat_dsc_pkts;
`endif

      // Error marker after two good beats (with a discarded filler in between)
      fifo_q.push_back(mkw(1, 0, 8'hFF, 64'hD1));
      fifo_q.push_back(mkw(0, 0, 8'h00, 64'hBAD));
      fifo_q.push_back(mkw(1, 0, 8'hFF, 64'hD2));
      fifo_q.push_back(mkw(0, 1, 8'h00, 64'hDEAD));
      drive();
      pkt_done_tgl = ~pkt_done_tgl;
      wait_beats(3, 30, "t3_nbeats");
      exp_q.push_back(bt(0, 8'hFF, 64'hD1, 0));
      exp_q.push_back(bt(0, 8'hFF, 64'hD2, 0));
      exp_q.push_back(bt(1, 8'hFF, 64'h0, 4'h8));
      check_cap("t3");
      step_n(2);
`ifdef TLP_TX_SCHED_STATS_EN
      chk("t3_stat_dsc", stat_dsc_pkts, dsc0 + 32'd1);
      chk("t3_stat_inj", stat_inj_pkts, 3);
`endif

      // Marker-only packet is dropped silently
      fifo_q.push_back(mkw(0, 1, 8'h00, 64'hDEAD));
      drive();
      pkt_done_tgl = ~pkt_done_tgl;
      step_n(10);
      chk("t3m_no_out", cap.size(), 0);
      chk("t3m_popped", fifo_q.size(), 0);
      chk("t3m_pending_0", pkt_pending, 0);
`ifdef TLP_TX_SCHED_STATS_EN
      chk("t3m_stat_dsc", stat_dsc_pkts, dsc0 + 32'd2);
`endif

      // Reset in the middle of an injected packet
      s_axis_tx_tready = 1'b0;
      fifo_q.push_back(mkw(1, 0, 8'hFF, 64'hE0));
      fifo_q.push_back(mkw(1, 1, 8'hFF, 64'hE9));
      drive();
      pkt_done_tgl = ~pkt_done_tgl;
      step_n(5);
      chk("t5_inj_active", s_axis_tx_tvalid, 1);
      #2;
      pcie_rst_n = 1'b0;
      #1;
      chk("t5_async_clear", s_axis_tx_tvalid, 0);
      fifo_q.delete();
      pkt_done_tgl = 1'b0; tgl2 = 1'b0;
      drive();
      step_n(2);
      pcie_rst_n = 1'b1;
      s_axis_tx_tready = 1'b1;
      step_n(2);
      chk("t5_pending_0", pkt_pending, 0);
      chk("t5_tvalid_0", s_axis_tx_tvalid, 0);
      chk("t5_no_beats", cap.size(), 0);
`ifdef TLP_TX_SCHED_STATS_EN
      chk("t5_stat_rst", stat_inj_pkts, 0);
`endif

      // Round-robin with local held valid; inc coincides with grant at count 1
      fifo_q.push_back(mkw(1, 0, 8'hFF, 64'hE1));
      fifo_q.push_back(mkw(1, 1, 8'hFF, 64'hE2));
      fifo_q.push_back(mkw(1, 0, 8'hFF, 64'hF1));
      fifo_q.push_back(mkw(1, 1, 8'h3F, 64'hF2));
      drive();
      pkt_done_tgl = ~pkt_done_tgl;
      step();
      pkt_done_tgl = ~pkt_done_tgl;
      step_n(3);
      chk("t4_inc_with_grant", pkt_pending, 1);
      chk("t4_inj_started", s_axis_tx_tvalid, 1);
      loc_q.push_back(bt(0, 8'hFF, 64'h1A, 4'h2));
      loc_q.push_back(bt(1, 8'h03, 64'h1B, 4'h2));
      loc_q.push_back(bt(1, 8'hFF, 64'h2A, 4'h2));
      drive();
      wait_beats(7, 60, "t4_nbeats");
      exp_q.push_back(bt(0, 8'hFF, 64'hE1, 0));
      exp_q.push_back(bt(1, 8'hFF, 64'hE2, 0));
      exp_q.push_back(bt(0, 8'hFF, 64'h1A, 4'h2));
      exp_q.push_back(bt(1, 8'h03, 64'h1B, 4'h2));
      exp_q.push_back(bt(0, 8'hFF, 64'hF1, 0));
      exp_q.push_back(bt(1, 8'h3F, 64'hF2, 0));
      exp_q.push_back(bt(1, 8'hFF, 64'h2A, 4'h2));
      check_cap("t4");
      step_n(2);

      // Counter saturation while the scheduler is parked in a stalled local packet
      s_axis_tx_tready = 1'b0;
      loc_q.push_back(bt(1, 8'hFF, 64'h5A, 4'h0));
      drive();
      step_n(2);
      for (int i = 0; i < 255; i++) begin
         pkt_done_tgl = ~pkt_done_tgl;
         step();
      end
      step_n(4);
      chk("sat_reach_255", pkt_pending, 255);
      pkt_done_tgl = ~pkt_done_tgl;
      step_n(4);
      chk("sat_hold_255", pkt_pending, 255);

      pcie_rst_n = 1'b0;
      #1;
      chk("end_rst_pending", pkt_pending, 0);
      chk("end_rst_loc_tready", loc_tready, 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
`default_nettype wire
